sram_controller: RTL and testbench

Data-memory responder between the EXE/MEM pipeline boundary and an external 16-bit asynchronous SRAM. Replaces the single-cycle data memory. It accepts one 32-bit word read or write per request, performs two half-word SRAM accesses with a programmable wait count, and holds `ready` low until the word is complete. The pipeline derives its global freeze as `~ready`.

---
 rtl/sram_controller.sv | 131 +++++++++++++
 tb/tb_sram_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit data-memory responder over a 16-bit asynchronous SRAM
// Each word is split into two half-word accesses; ready stays low until the word completes.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        is_write;
  logic        req;
  logic        phase_end;
  logic [31:0] word_off;
  logic [16:0] idx;
  logic        unused_addr_bits;

  logic [17:0] sram_addr_nx;
  logic [15:0] sram_dq_out_nx;
  logic        sram_dq_oe_nx;
  logic        sram_we_n_nx;

  assign req              = wr_en | rd_en;
  assign phase_end        = (cnt == 4'd0);
  assign word_off         = address - BASE_ADDR;
  assign idx              = word_off[18:2];
  assign unused_addr_bits = &{1'b0, word_off[31:19], word_off[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LOW;
      LOW:     if (phase_end) state_nx = HIGH;
      HIGH:    if (phase_end) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // SRAM pins are registered and only reloaded on state transitions, so they hold across each half-phase.
  always_comb begin
    ready          = !(((state != DONE) && req) || (state == LOW) || (state == HIGH));
    sram_addr_nx   = sram_addr;
    sram_dq_out_nx = sram_dq_out;
    sram_dq_oe_nx  = sram_dq_oe;
    sram_we_n_nx   = sram_we_n;
    case (state)
      IDLE: if (req) begin
        sram_addr_nx   = {idx, 1'b0};
        sram_dq_out_nx = write_data[15:0];
        sram_dq_oe_nx  = wr_en;
        sram_we_n_nx   = !wr_en;
      end
      LOW: if (phase_end) begin
        sram_addr_nx   = {idx, 1'b1};
        sram_dq_out_nx = write_data[31:16];
      end
      HIGH: if (phase_end) begin
        sram_addr_nx   = 18'd0;
        sram_dq_out_nx = 16'd0;
        sram_dq_oe_nx  = 1'b0;
        sram_we_n_nx   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      is_write    <= 1'b0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      sram_addr   <= sram_addr_nx;
      sram_dq_out <= sram_dq_out_nx;
      sram_dq_oe  <= sram_dq_oe_nx;
      sram_we_n   <= sram_we_n_nx;
      case (state)
        IDLE: begin
          if (req) begin
            cnt      <= CNT_LOAD;
            is_write <= wr_en;
          end
        end
        LOW: begin
          if (phase_end) begin
            cnt <= CNT_LOAD;
            if (!is_write) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cnt <= 4'd0;
            if (!is_write) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller
// Checks cycle-by-cycle pin behaviour and read data against a word-level memory model.
module tb_sram_controller;

  localparam int AC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] mem [0:4095];
  logic [31:0] ref_mem [int];
  logic [31:0] last_read;

  sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write committed while we_n is low.
  assign sram_dq_in = mem[sram_addr[11:0]];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    forever begin
      @(posedge clk);
      if (!sram_we_n) mem[sram_addr[11:0]] <= sram_dq_out;
    end
  end

  function automatic logic [31:0] ref_read(input int widx);
    if (ref_mem.exists(widx)) return ref_mem[widx];
    return 32'd0;
  endfunction

  task automatic check_idle_pins(input string name);
    @(negedge clk);
    n_total++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
        sram_addr !== 18'd0 || sram_dq_out !== 16'd0)
      $display("FAIL %s: ready=%b we_n=%b oe=%b addr=%0d dq=%h, required ready=1 we_n=1 oe=0 addr=0 dq=0",
               name, ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out);
    else n_pass++;
  endtask

  // Issues one request starting in an IDLE cycle; returns #1 after the edge that ends DONE.
  task automatic run_req(input string name, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    int          widx;
    int          errs;
    string       first;
    logic        is_wr;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic        e_ready, active, half;
    off   = addr - 32'd1024;
    widx  = int'(off >> 2);
    is_wr = wr;
    errs  = 0;
    first = "";
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    for (int c = 0; c <= 2 * AC + 1; c++) begin
      @(negedge clk);
      e_ready = (c == 2 * AC + 1);
      active  = (c >= 1) && (c <= 2 * AC);
      half    = (c > AC);
      e_addr  = active ? {off[18:2], half} : 18'd0;
      e_dq    = !active ? 16'd0 : (half ? data[31:16] : data[15:0]);
      if (ready !== e_ready || sram_addr !== e_addr ||
          sram_we_n !== !(active && is_wr) || sram_dq_oe !== (active && is_wr) ||
          ((is_wr || !active) && sram_dq_out !== e_dq)) begin
        if (errs == 0)
          first = $sformatf("cycle %0d ready=%b addr=%0d we_n=%b oe=%b dq=%h, required ready=%b addr=%0d we_n=%b oe=%b dq=%h",
                            c, ready, sram_addr, sram_we_n, sram_dq_oe, sram_dq_out,
                            e_ready, e_addr, !(active && is_wr), active && is_wr, e_dq);
        errs++;
      end
      if (c == 2 * AC + 1) begin
        if (!is_wr) last_read = ref_read(widx);
        n_total++;
        if (read_data !== last_read)
          $display("FAIL %s read_data: got %h, required %h", name, read_data, last_read);
        else n_pass++;
      end
      if (c < 2 * AC + 1) @(posedge clk);
    end
    n_total++;
    if (errs != 0) $display("FAIL %s pins: %0d bad cycles, first %s", name, errs, first);
    else n_pass++;
    if (is_wr) ref_mem[widx] = data;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    last_read = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_pins("reset_pins");
    n_total++;
    if (read_data !== 32'd0) $display("FAIL reset_read_data: got %h, required 0", read_data);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    run_req("write_deadbeef", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check_idle_pins("idle_after_write");
    @(posedge clk); #1;
    run_req("read_deadbeef", 1'b0, 1'b1, 32'd1024, 32'h0);
    n_total++;
    if (last_read !== 32'hDEADBEEF) $display("FAIL read_deadbeef model: got %h, required deadbeef", last_read);
    else n_pass++;
  endtask

  task automatic test_addr_map;
    run_req("addr_map_1032", 1'b1, 1'b0, 32'd1032, 32'h12345678);
  endtask

  task automatic test_back_to_back;
    run_req("b2b_write", 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D);
    run_req("b2b_read", 1'b0, 1'b1, 32'd1036, 32'h0);
    n_total++;
    if (read_data !== 32'hCAFEF00D) $display("FAIL b2b_value: got %h, required cafef00d", read_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024 + 32'd8000; write_data = $urandom;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    last_read = 32'd0;
    @(negedge clk);
    n_total++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'd0 || ready !== 1'b1)
      $display("FAIL reset_mid: we_n=%b oe=%b read_data=%h ready=%b, required 1 0 00000000 1",
               sram_we_n, sram_dq_oe, read_data, ready);
    else n_pass++;
    @(posedge clk); #1;
    run_req("read_after_reset", 1'b0, 1'b1, 32'd1024, 32'h0);
  endtask

  task automatic test_both_enables;
    run_req("both_en_write", 1'b1, 1'b1, 32'd1024, 32'h0000FFFF);
    run_req("both_en_readback", 1'b0, 1'b1, 32'd1024, 32'h0);
    n_total++;
    if (read_data !== 32'h0000FFFF) $display("FAIL both_en_value: got %h, required 0000ffff", read_data);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = 32'd1024 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      run_req($sformatf("rand%0d", i), op != 1, op != 0, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        check_idle_pins($sformatf("rand_idle%0d", i));
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_map();
    test_back_to_back();
    test_reset_mid();
    test_both_enables();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
